// File: rtl/uart_pkg.sv
// Shared types and widths for the UART transmit path.
//   tx_sched_state_t : scheduler states (IDLE, LAUNCH, WAIT, GAP)
//   UART_DATA_W      : width of one UART data byte
package uart_pkg;

    localparam int unsigned UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        GAP    = 2'd3
    } tx_sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter with an optional lock to one requester.
// Ports:
//   req         : request vector
//   ptr         : index where the search starts (wraps at NUM_REQ)
//   lock        : when set, only lock_id may win
//   lock_id     : locked requester
//   grant_valid : some requester won
//   grant_idx   : index of the winner
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               lock,
    input  logic [ID_W-1:0]    lock_id,
    output logic               grant_valid,
    output logic [ID_W-1:0]    grant_idx
);

    localparam int unsigned DW = 2 * NUM_REQ;

    logic [NUM_REQ-1:0] w_req_elig;
    logic [DW-1:0]      w_dbl;
    logic [DW-1:0]      w_masked;

    // Upper copy of the request vector provides the wrap-around; masking the
    // bits below ptr makes the lowest surviving bit the round-robin winner.
    always_comb begin
        w_req_elig  = lock ? (req & (NUM_REQ'(1) << lock_id)) : req;
        w_dbl       = {w_req_elig, w_req_elig};
        w_masked    = w_dbl & ({DW{1'b1}} << ptr);
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = DW - 1; i >= 0; i--) begin
            if (w_masked[i]) begin
                grant_valid = 1'b1;
                grant_idx   = ID_W'(i % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ producers.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   req_valid    : per-requester byte available
//   req_data     : requester i byte at [8i+7:8i]
//   req_last     : byte ends requester i's packet
//   req_ready    : one-hot accept pulse (LAUNCH cycle)
//   uart_dintx   : byte to transmitter, held until donetx
//   uart_send    : one-cycle start pulse to transmitter
//   uart_donetx  : frame complete from transmitter
//   busy         : scheduler not idle
//   grant_id     : current or most recent grantee
//   timeout_err  : one-cycle pulse when the donetx wait expires
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned GAP_CYCLES     = 0,
    parameter int unsigned TIMEOUT_CYCLES = 2048
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [UART_DATA_W-1:0]         uart_dintx,
    output logic                           uart_send,
    input  logic                           uart_donetx,
    output logic                           busy,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic                           timeout_err
);

    localparam int unsigned ID_W     = $clog2(NUM_REQ);
    localparam int unsigned TO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    tx_sched_state_t         r_state, w_state_nxt;
    logic [ID_W-1:0]         r_ptr, w_ptr_nxt;
    logic                    r_lock, w_lock_nxt;
    logic [ID_W-1:0]         r_lock_id, w_lock_id_nxt;
    logic                    r_last, w_last_nxt;
    logic [TO_W-1:0]         r_to_cnt, w_to_cnt_nxt;
    logic [GAP_W-1:0]        r_gap_cnt, w_gap_cnt_nxt;
    logic [UART_DATA_W-1:0]  r_dintx, w_dintx_nxt;
    logic                    r_send, w_send_nxt;
    logic [NUM_REQ-1:0]      r_ready, w_ready_nxt;
    logic                    r_busy, w_busy_nxt;
    logic [ID_W-1:0]         r_grant_id, w_grant_id_nxt;
    logic                    r_timeout_err, w_timeout_err_nxt;

    logic                    w_grant_valid;
    logic [ID_W-1:0]         w_grant_idx;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req         (req_valid),
        .ptr         (r_ptr),
        .lock        (r_lock),
        .lock_id     (r_lock_id),
        .grant_valid (w_grant_valid),
        .grant_idx   (w_grant_idx)
    );

    // State, counters, capture and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_ptr         <= '0;
            r_lock        <= 1'b0;
            r_lock_id     <= '0;
            r_last        <= 1'b0;
            r_to_cnt      <= '0;
            r_gap_cnt     <= '0;
            r_dintx       <= '0;
            r_send        <= 1'b0;
            r_ready       <= '0;
            r_busy        <= 1'b0;
            r_grant_id    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_ptr         <= w_ptr_nxt;
            r_lock        <= w_lock_nxt;
            r_lock_id     <= w_lock_id_nxt;
            r_last        <= w_last_nxt;
            r_to_cnt      <= w_to_cnt_nxt;
            r_gap_cnt     <= w_gap_cnt_nxt;
            r_dintx       <= w_dintx_nxt;
            r_send        <= w_send_nxt;
            r_ready       <= w_ready_nxt;
            r_busy        <= w_busy_nxt;
            r_grant_id    <= w_grant_id_nxt;
            r_timeout_err <= w_timeout_err_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt       = r_state;
        w_ptr_nxt         = r_ptr;
        w_lock_nxt        = r_lock;
        w_lock_id_nxt     = r_lock_id;
        w_last_nxt        = r_last;
        w_to_cnt_nxt      = r_to_cnt;
        w_gap_cnt_nxt     = r_gap_cnt;
        w_dintx_nxt       = r_dintx;
        w_send_nxt        = 1'b0;
        w_ready_nxt       = '0;
        w_grant_id_nxt    = r_grant_id;
        w_timeout_err_nxt = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_grant_valid) begin
                    w_state_nxt    = LAUNCH;
                    w_dintx_nxt    = req_data[UART_DATA_W*w_grant_idx +: UART_DATA_W];
                    w_last_nxt     = req_last[w_grant_idx];
                    w_grant_id_nxt = w_grant_idx;
                    w_send_nxt     = 1'b1;
                    w_ready_nxt    = NUM_REQ'(1) << w_grant_idx;
                end
            end
            // Byte is accepted here; donetx in this cycle belongs to the
            // previous frame and is deliberately not looked at.
            LAUNCH: begin
                w_state_nxt  = WAIT;
                w_to_cnt_nxt = '0;
                if (r_last) begin
                    w_lock_nxt = 1'b0;
                    w_ptr_nxt  = (r_grant_id == ID_W'(NUM_REQ - 1)) ? '0
                                                                    : r_grant_id + ID_W'(1);
                end else begin
                    w_lock_nxt    = 1'b1;
                    w_lock_id_nxt = r_grant_id;
                end
            end
            // donetx has priority over an expiring timeout in the same cycle.
            // The counter only increments below TIMEOUT_CYCLES, so it saturates.
            WAIT: begin
                if (uart_donetx) begin
                    if (GAP_CYCLES > 0) begin
                        w_state_nxt   = GAP;
                        w_gap_cnt_nxt = '0;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (r_to_cnt == TO_W'(TIMEOUT_CYCLES)) begin
                    w_state_nxt       = IDLE;
                    w_timeout_err_nxt = 1'b1;
                    w_lock_nxt        = 1'b0;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + TO_W'(1);
                end
            end
            GAP: begin
                if (r_gap_cnt == GAP_W'(GAP_LAST)) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + GAP_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != IDLE);
    end

    assign req_ready   = r_ready;
    assign uart_dintx  = r_dintx;
    assign uart_send   = r_send;
    assign busy        = r_busy;
    assign grant_id    = r_grant_id;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: the UART transmitter is modelled by a
// responder that returns donetx a fixed number of cycles after uart_send.
module tb_uart_tx_sched;

    localparam int NR  = 4;
    localparam int GAP = 5;
    localparam int TO  = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [7:0]  uart_dintx;
    logic        uart_send;
    logic        uart_donetx;
    logic        busy;
    logic [1:0]  grant_id;
    logic        timeout_err;

    logic resp_done;
    logic force_done;
    assign uart_donetx = resp_done | force_done;

    always #5 clk = ~clk;

    uart_tx_sched #(
        .NUM_REQ        (NR),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .uart_dintx  (uart_dintx),
        .uart_send   (uart_send),
        .uart_donetx (uart_donetx),
        .busy        (busy),
        .grant_id    (grant_id),
        .timeout_err (timeout_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Per-requester byte queues
    logic [7:0] m_data [4][16];
    logic       m_last [4][16];
    int         head [4];
    int         tail [4];

    // Responder and event logs
    int         cyc;
    int         done_at;
    int         resp_frame;
    bit         resp_en;
    logic [7:0] cur_byte;
    logic       prev_busy;
    int         fall_cyc;
    int         terr_cyc;
    int         terr_cnt;
    int         grant_log [$];
    int         send_log  [$];
    int         done_log  [$];
    logic [7:0] dintx_log [$];

    task automatic push(input int r, input logic [7:0] d, input logic l);
        m_data[r][tail[r]] = d;
        m_last[r][tail[r]] = l;
        tail[r]++;
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            if (head[i] < tail[i]) begin
                req_valid[i]      = 1'b1;
                req_data[8*i +: 8] = m_data[i][head[i]];
                req_last[i]       = m_last[i][head[i]];
            end else begin
                req_valid[i]      = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]       = 1'b0;
            end
        end
    endtask

    task automatic clear_state();
        for (int i = 0; i < NR; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        resp_done  = 1'b0;
        force_done = 1'b0;
        done_at    = -1;
        prev_busy  = 1'b0;
        fall_cyc   = -1;
        terr_cyc   = -1;
        terr_cnt   = 0;
        cur_byte   = 8'h00;
        grant_log.delete();
        send_log.delete();
        done_log.delete();
        dintx_log.delete();
        drive();
    endtask

    // One clock: observe outputs #1 after the edge, then update stimulus.
    task automatic tick();
        int idx;
        @(posedge clk);
        #1;
        cyc++;
        if (uart_send || req_ready != 4'b0) begin
            chk("ready_with_send", 32'({uart_send, req_ready}),
                32'({1'b1, 4'(4'b0001 << grant_id)}));
        end
        if (uart_send) begin
            idx = int'(grant_id);
            grant_log.push_back(idx);
            send_log.push_back(cyc);
            dintx_log.push_back(uart_dintx);
            cur_byte = (head[idx] < tail[idx]) ? m_data[idx][head[idx]] : 8'h00;
            if (resp_en) done_at = cyc + resp_frame;
        end
        if (done_at == cyc) begin
            resp_done = 1'b1;
            done_log.push_back(cyc);
            chk("dintx_hold", 32'(uart_dintx), 32'(cur_byte));
        end else begin
            resp_done = 1'b0;
        end
        if (timeout_err) begin
            terr_cyc = cyc;
            terr_cnt++;
        end
        if (prev_busy && !busy) fall_cyc = cyc;
        prev_busy = busy;
        for (int i = 0; i < NR; i++) begin
            if (req_ready[i] && head[i] < tail[i]) head[i]++;
        end
        drive();
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        clear_state();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_sends(input int n, input int budget, input string tag);
        for (int k = 0; k < budget && send_log.size() < n; k++) tick();
        chk(tag, 32'(send_log.size()), 32'(n));
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k = 0;
        do begin
            tick();
            k++;
        end while (busy && k < budget);
        chk(tag, 32'(busy), 32'(0));
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_send"},  32'(uart_send),   32'(0));
        chk({pfx, "_dintx"}, 32'(uart_dintx),  32'(0));
        chk({pfx, "_ready"}, 32'(req_ready),   32'(0));
        chk({pfx, "_busy"},  32'(busy),        32'(0));
        chk({pfx, "_grant"}, 32'(grant_id),    32'(0));
        chk({pfx, "_terr"},  32'(timeout_err), 32'(0));
    endtask

    initial begin
        int         c0;
        int         exp_g [6];
        logic [7:0] exp_b [6];

        cyc        = 0;
        resp_en    = 1'b1;
        resp_frame = 5;
        req_valid  = '0;
        req_data   = '0;
        req_last   = '0;

        // Reset values
        reset_dut();
        chk_reset_vals("rst");

        // Single byte from requester 2: one-cycle acceptance latency
        push(2, 8'hAA, 1'b1);
        drive();
        c0 = cyc;
        wait_sends(1, 20, "t1_send");
        chk("t1_latency", 32'(send_log[0] - c0), 32'(1));
        chk("t1_grant", 32'(grant_log[0]), 32'(2));
        chk("t1_dintx", 32'(dintx_log[0]), 32'(8'hAA));
        wait_idle(40, "t1_idle");
        chk("t1_busy_fall", 32'(fall_cyc - done_log[0]), 32'(GAP + 1));
        chk("t1_terr", 32'(terr_cnt), 32'(0));

        // Round robin from ptr=0, requester 0 has a second byte
        reset_dut();
        push(0, 8'h10, 1'b1);
        push(1, 8'h11, 1'b1);
        push(2, 8'h12, 1'b1);
        push(3, 8'h13, 1'b1);
        push(0, 8'h50, 1'b1);
        drive();
        wait_sends(5, 120, "t2_sends");
        exp_g = '{0, 1, 2, 3, 0, 0};
        exp_b = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h50, 8'h00};
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t2_grant%0d", k), 32'(grant_log[k]), 32'(exp_g[k]));
            chk($sformatf("t2_byte%0d", k), 32'(dintx_log[k]), 32'(exp_b[k]));
        end
        chk("t2_spacing", 32'(send_log[1] - send_log[0]), 32'(5 + GAP + 2));
        chk("t2_done_to_send", 32'(send_log[1] - done_log[0]), 32'(GAP + 2));
        wait_idle(40, "t2_idle");

        // Packet lock: requester 1 sends three bytes; others join during LAUNCH
        reset_dut();
        push(1, 8'h31, 1'b0);
        push(1, 8'h32, 1'b0);
        push(1, 8'h33, 1'b1);
        drive();
        wait_sends(1, 10, "t3_first");
        push(0, 8'h20, 1'b1);
        push(2, 8'h42, 1'b1);
        push(3, 8'h43, 1'b1);
        drive();
        wait_sends(6, 150, "t3_sends");
        exp_g = '{1, 1, 1, 2, 3, 0};
        exp_b = '{8'h31, 8'h32, 8'h33, 8'h42, 8'h43, 8'h20};
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("t3_grant%0d", k), 32'(grant_log[k]), 32'(exp_g[k]));
            chk($sformatf("t3_byte%0d", k), 32'(dintx_log[k]), 32'(exp_b[k]));
        end
        wait_idle(40, "t3_idle");

        // Timeout: no donetx; 17 WAIT cycles lie between LAUNCH and the pulse
        reset_dut();
        resp_en = 1'b0;
        push(1, 8'h51, 1'b0);
        drive();
        wait_sends(1, 10, "t4_first");
        push(0, 8'h50, 1'b1);
        drive();
        wait_sends(2, 40, "t4_regrant");
        chk("t4_terr_cnt", 32'(terr_cnt), 32'(1));
        chk("t4_terr_time", 32'(terr_cyc - send_log[0]), 32'(TO + 2));
        chk("t4_regrant_time", 32'(send_log[1] - terr_cyc), 32'(1));
        chk("t4_regrant_id", 32'(grant_log[1]), 32'(0));
        wait_idle(40, "t4_idle");
        chk("t4_terr_cnt2", 32'(terr_cnt), 32'(2));

        // donetx in the same cycle the timeout expires: done wins
        reset_dut();
        resp_en    = 1'b1;
        resp_frame = TO + 1;
        push(3, 8'h77, 1'b1);
        drive();
        wait_sends(1, 10, "t4b_send");
        wait_idle(60, "t4b_idle");
        chk("t4b_terr", 32'(terr_cnt), 32'(0));
        chk("t4b_fall", 32'(fall_cyc - done_log[0]), 32'(GAP + 1));

        // Stale donetx during LAUNCH is ignored
        reset_dut();
        resp_frame = 5;
        push(2, 8'h5A, 1'b1);
        drive();
        wait_sends(1, 10, "t5_send");
        force_done = 1'b1;
        tick();
        force_done = 1'b0;
        wait_idle(40, "t5_idle");
        chk("t5_fall", 32'(fall_cyc - send_log[0]), 32'(5 + GAP + 1));

        // Reset during WAIT: asynchronous clear, lock dropped
        reset_dut();
        push(1, 8'h61, 1'b0);
        drive();
        wait_sends(1, 10, "t6_send");
        push(0, 8'h60, 1'b1);
        drive();
        repeat (3) tick();
        chk("t6_busy_pre", 32'(busy), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("t6_async");
        clear_state();
        push(0, 8'h60, 1'b1);
        push(1, 8'h62, 1'b1);
        drive();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_sends(1, 10, "t6_resend");
        chk("t6_grant", 32'(grant_log[0]), 32'(0));
        chk("t6_byte", 32'(dintx_log[0]), 32'(8'h60));
        wait_idle(40, "t6_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got time %0t, expected completion", $time);
        $fatal(1);
    end

endmodule
